// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer
// Wishbone write master that pushes an 8-row frame buffer to the 8x8 RGB
// matrix driver. Every row is rotated left by 4*offset bits (one LED per
// nibble) on its way out. The offset steps after each complete frame.
// Frames are started by a period timer or by a forced trigger. Both sources
// share a single pending flag. The data path supports only a 32-bit bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released; waiting for a pending trigger
// REQ      | cyc/stb high for the current row; waiting for !stall
// WAIT_ACK | cyc high, stb low; waiting for the slave ack
// DONE     | bus released; pulse frame_done, step the scroll offset

module matrix_frame_sequencer #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 3,
    parameter int TICK_WIDTH    = 24,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_enable,
    input  logic [TICK_WIDTH-1:0]    i_period,
    input  logic                     i_dir,
    input  logic                     i_force,
    input  logic                     i_load_we,
    input  logic [2:0]               i_load_row,
    input  logic [WB_DATA_WIDTH-1:0] i_load_data,
    input  logic                     i_err_clr,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic [2:0]               o_offset,
    output logic                     o_err,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [3:0]               o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall
);

    localparam int DW    = WB_DATA_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    // The abort fires on the cycle in which the counter would reach TIMEOUT.
    // This keeps cyc high for exactly TIMEOUT cycles on a dead slave.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [DW-1:0]           frame_q [8];
    logic [TICK_WIDTH-1:0]   timer_q, timer_d;
    logic                    pending_q, pending_d;
    logic [2:0]              row_q;
    logic [2:0]              offset_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    cyc_q, stb_q;
    logic [WB_ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]           wdata_q;
    logic                    frame_done_q;
    logic                    err_q;

    logic                    trig_consume;
    logic [TICK_WIDTH-1:0]   period_last;
    logic [2:0]              row_next;
    logic                    ack_now;
    logic                    tmo_hit;
    logic                    last_row;
    logic [DW-1:0]           row0_rot;
    logic [DW-1:0]           next_rot;

    // Rotate left by whole LEDs (nibbles). Column 0 sits in the top nibble.
    function automatic logic [DW-1:0] rotl_nib(input logic [DW-1:0] d,
                                               input logic [2:0]    n);
        logic [2*DW-1:0] dd;
        dd = {d, d} << {n, 2'b00};
        return dd[2*DW-1:DW];
    endfunction

    assign trig_consume = (state_q == ST_IDLE) && pending_q;
    assign period_last  = i_period - TICK_WIDTH'(1);
    assign row_next     = row_q + 3'd1;
    assign last_row     = (row_q == 3'd7);
    assign tmo_hit      = (tmo_q == TMO_LAST);
    // An ack in the same cycle that stb is accepted counts as the ack.
    assign ack_now      = ((state_q == ST_REQ) && !i_wb_stall && i_wb_ack) ||
                          ((state_q == ST_WAIT_ACK) && i_wb_ack);
    // Data is sampled from the buffer as REQ is entered. A same-cycle load
    // to that row is therefore not seen by this frame.
    assign row0_rot     = rotl_nib(frame_q[0], offset_q);
    assign next_rot     = rotl_nib(frame_q[row_next], offset_q);

    // Frame buffer write port, open in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                frame_q[i] <= '0;
            end
        end else if (i_load_we) begin
            frame_q[i_load_row] <= i_load_data;
        end
    end

    // Next-state logic for the period timer and the shared pending flag.
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        if (trig_consume) begin
            pending_d = 1'b0;
        end
        if (!i_enable || (i_period == '0)) begin
            timer_d = '0;
        end else if (!pending_q || trig_consume) begin
            // The timer keeps counting in the cycle in which IDLE takes the
            // trigger. This keeps the frame start spacing at exactly i_period.
            if (timer_q >= period_last) begin
                timer_d   = '0;
                pending_d = 1'b1;
            end else begin
                timer_d = timer_q + TICK_WIDTH'(1);
            end
        end
        if (i_force) begin
            pending_d = 1'b1;
        end
    end

    // Timer and pending flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // Frame sequencer FSM with registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            offset_q     <= '0;
            tmo_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // A timeout that sets the flag later in this block overrides this clear.
            if (i_err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trig_consume) begin
                        state_q <= ST_REQ;
                        row_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= row0_rot;
                        tmo_q   <= '0;
                    end
                end
                ST_REQ, ST_WAIT_ACK: begin
                    if (ack_now) begin
                        if (last_row) begin
                            state_q      <= ST_DONE;
                            cyc_q        <= 1'b0;
                            stb_q        <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_REQ;
                            row_q   <= row_next;
                            stb_q   <= 1'b1;
                            addr_q  <= WB_ADDR_WIDTH'(row_next);
                            wdata_q <= next_rot;
                            tmo_q   <= '0;
                        end
                    end else if (tmo_hit) begin
                        // Abort the frame. The offset is left alone and no done pulse is issued.
                        state_q <= ST_IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        if ((state_q == ST_REQ) && !i_wb_stall) begin
                            state_q <= ST_WAIT_ACK;
                            stb_q   <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b0;
                    offset_q     <= i_dir ? (offset_q - 3'd1) : (offset_q + 3'd1);
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = frame_done_q;
    assign o_offset     = offset_q;
    assign o_err        = err_q;
    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = cyc_q;
    assign o_wb_sel     = {4{cyc_q}};
    assign o_wb_addr    = addr_q;
    assign o_wb_wdata   = wdata_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed bench for matrix_frame_sequencer. A small Wishbone slave acks one
// cycle after each accepted stb. It can be told to stall one row or to
// withhold the ack entirely.

module tb_matrix_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_enable = 1'b0;
    logic [23:0] i_period = '0;
    logic        i_dir = 1'b0;
    logic        i_force = 1'b0;
    logic        i_load_we = 1'b0;
    logic [2:0]  i_load_row = '0;
    logic [31:0] i_load_data = '0;
    logic        i_err_clr = 1'b0;
    logic        o_busy, o_frame_done, o_err;
    logic [2:0]  o_offset;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cnt = 0;

    logic        ack_en = 1'b1;
    int          stall_row = -1;
    int          stall_left = 0;
    int          hold_cnt = 0;
    int          done_cnt = 0;
    logic        accept_q = 1'b0;
    logic [2:0]  wr_addr [$];
    logic [31:0] wr_data [$];

    matrix_frame_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enable     (i_enable),
        .i_period     (i_period),
        .i_dir        (i_dir),
        .i_force      (i_force),
        .i_load_we    (i_load_we),
        .i_load_row   (i_load_row),
        .i_load_data  (i_load_data),
        .i_err_clr    (i_err_clr),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_offset     (o_offset),
        .o_err        (o_err),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_sel     (o_wb_sel),
        .o_wb_wdata   (o_wb_wdata),
        .i_wb_ack     (i_wb_ack),
        .i_wb_stall   (i_wb_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Slave model and write logger, evaluated on the falling edge.
    always @(negedge clk) begin
        i_wb_ack = ack_en && accept_q;
        if (o_wb_cyc && o_wb_stb && stall_left > 0 && int'(o_wb_addr) == stall_row) begin
            i_wb_stall = 1'b1;
            stall_left--;
            if (o_wb_wdata == 32'h33333333) hold_cnt++;
        end else begin
            i_wb_stall = 1'b0;
        end
        accept_q = o_wb_cyc && o_wb_stb && !i_wb_stall;
        if (accept_q) begin
            wr_addr.push_back(o_wb_addr);
            wr_data.push_back(o_wb_wdata);
        end
        if (o_frame_done) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_val(input int sel);
        return (sel == 0) ? o_wb_cyc : o_frame_done;
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input int budget,
                            input string tag, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            if (sel_val(sel) === lvl) begin
                t = cnt;
                break;
            end
            step();
        end
        vectors++;
        assert (t >= 0) else begin
            miscompares++;
            $error("FAIL %s: observed no event within %0d cycles, expected event", tag, budget);
        end
    endtask

    task automatic pulse_force(output int f);
        wr_addr.delete();
        wr_data.delete();
        f = cnt;
        i_force = 1'b1;
        step();
        i_force = 1'b0;
    endtask

    task automatic load_rows();
        for (int r = 0; r < 8; r++) begin
            i_load_we   = 1'b1;
            i_load_row  = 3'(r);
            i_load_data = (r == 0) ? 32'h12345678 : 32'h11111111 * 32'(r);
            step();
        end
        i_load_we = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp0, input bit zeros);
        logic [2:0]  a;
        logic [31:0] d, e;
        chk({tag, "_nwr"}, wr_addr.size(), 8);
        for (int r = 0; r < 8; r++) begin
            a = (r < wr_addr.size()) ? wr_addr[r] : 3'bxxx;
            d = (r < wr_data.size()) ? wr_data[r] : 32'hxxxxxxxx;
            e = (r == 0) ? exp0 : (zeros ? 32'h0 : 32'h11111111 * 32'(r));
            chk($sformatf("%s_addr%0d", tag, r), a, r);
            chk($sformatf("%s_data%0d", tag, r), d, e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cyc"},   o_wb_cyc, 0);
        chk({tag, "_stb"},   o_wb_stb, 0);
        chk({tag, "_we"},    o_wb_we, 0);
        chk({tag, "_addr"},  o_wb_addr, 0);
        chk({tag, "_sel"},   o_wb_sel, 0);
        chk({tag, "_wdata"}, o_wb_wdata, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_frame_done, 0);
        chk({tag, "_off"},   o_offset, 0);
        chk({tag, "_err"},   o_err, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int f, t, t1, t2, e, d0;

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        chk_zero("rst");
        reset_n = 1'b1;
        step();
        load_rows();

        // Force at offset 0, scroll left
        i_dir = 1'b0;
        d0 = done_cnt;
        pulse_force(f);
        wait_sig(0, 1'b1, 10, "a_cyc_wait", t);
        chk("a_lat_cyc", t - f, 2);
        chk("a_busy", o_busy, 1);
        chk("a_sel", o_wb_sel, 4'hf);
        chk("a_we", o_wb_we, 1);
        wait_sig(1, 1'b1, 40, "a_done_wait", t);
        chk("a_lat_done", t - f, 18);
        step();
        chk("a_done_pulse", o_frame_done, 0);
        chk("a_offset", o_offset, 1);
        chk("a_idle", o_busy, 0);
        chk("a_done_cnt", done_cnt - d0, 1);
        check_frame("a", 32'h12345678, 1'b0);

        // Second force, left
        pulse_force(f);
        wait_sig(1, 1'b1, 40, "b_done_wait", t);
        step();
        chk("b_offset", o_offset, 2);
        check_frame("b", 32'h23456781, 1'b0);

        // Reset clears the buffer and offset
        do_reset();
        chk("c_off_rst", o_offset, 0);
        pulse_force(f);
        wait_sig(1, 1'b1, 40, "c_done_wait", t);
        step();
        chk("c_offset", o_offset, 1);
        check_frame("c", 32'h0, 1'b1);

        // Right scroll with wrap
        do_reset();
        load_rows();
        i_dir = 1'b1;
        pulse_force(f);
        wait_sig(1, 1'b1, 40, "d1_done_wait", t);
        step();
        chk("d1_offset", o_offset, 7);
        check_frame("d1", 32'h12345678, 1'b0);
        pulse_force(f);
        wait_sig(1, 1'b1, 40, "d2_done_wait", t);
        step();
        chk("d2_offset", o_offset, 6);
        check_frame("d2", 32'h81234567, 1'b0);

        // Three stall cycles on row 3
        stall_row  = 3;
        stall_left = 3;
        hold_cnt   = 0;
        pulse_force(f);
        wait_sig(1, 1'b1, 40, "e_done_wait", t);
        chk("e_lat_done", t - f, 21);
        chk("e_hold", hold_cnt, 3);
        step();
        chk("e_offset", o_offset, 5);
        check_frame("e", 32'h78123456, 1'b0);
        stall_row = -1;

        // Ack timeout
        ack_en = 1'b0;
        d0 = done_cnt;
        pulse_force(f);
        wait_sig(0, 1'b1, 10, "f_cyc_wait", t1);
        wait_sig(0, 1'b0, 300, "f_drop_wait", t);
        chk("f_cyc_len", t - t1, 255);
        chk("f_drop_time", t - f, 257);
        chk("f_err", o_err, 1);
        chk("f_stb", o_wb_stb, 0);
        chk("f_busy", o_busy, 0);
        chk("f_offset", o_offset, 5);
        chk("f_no_done", done_cnt - d0, 0);
        step();
        chk("f_err_sticky", o_err, 1);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("f_err_clr", o_err, 0);
        ack_en = 1'b1;
        step();

        // Period timer, then async reset mid-frame
        i_dir    = 1'b0;
        i_period = 24'd40;
        e = cnt;
        i_enable = 1'b1;
        wait_sig(0, 1'b1, 60, "g_cyc1_wait", t1);
        chk("g_first_start", t1 - e, 41);
        wait_sig(0, 1'b0, 30, "g_cyc1_end", t);
        wait_sig(0, 1'b1, 60, "g_cyc2_wait", t2);
        chk("g_period", t2 - t1, 40);
        chk("g_offset", o_offset, 6);
        step();
        step();
        step();
        chk("g_mid_cyc", o_wb_cyc, 1);
        reset_n = 1'b0;
        #1;
        chk_zero("g_rst");
        i_enable = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_frame_sequencer.md
# matrix_frame_sequencer

Wishbone master that drives the 8x8 RGB matrix driver's eight row registers (one 32-bit word per row, nibble `xRGB` per LED, column 0 in bits [31:28]). It holds a local 8-row frame buffer that is loaded through a simple write port. Each frame update writes all eight rows to the matrix, with every row rotated horizontally by a scroll offset. Updates fire on a programmable period timer or on a forced trigger, and the offset steps left or right after each successful frame.

## Interface
Parameters:
- `WB_DATA_WIDTH`, 32: bus data width. Only 32 is supported.
- `WB_ADDR_WIDTH`, 3: register address width, one address per row.
- `TICK_WIDTH`, 24: width of the period timer.
- `TIMEOUT`, 255: maximum number of cycles spent in REQ or WAIT_ACK before the frame aborts.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `i_enable` in 1: enables the period timer.
- `i_period` in TICK_WIDTH: frame period in clk cycles. 0 means no timed updates.
- `i_dir` in 1: 0 = scroll left (offset +1), 1 = scroll right (offset −1).
- `i_force` in 1: one-cycle request for an immediate frame update.
- `i_load_we` in 1: write strobe into the frame buffer.
- `i_load_row` in 3: buffer row to write.
- `i_load_data` in 32: buffer row data.
- `i_err_clr` in 1: clears `o_err`.
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_frame_done` out 1: one-cycle pulse when a frame completes successfully.
- `o_offset` out 3: current scroll offset.
- `o_err` out 1: sticky flag, set on ack timeout.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master controls. `we` is high for every transfer.
- `o_wb_addr` out WB_ADDR_WIDTH: row index.
- `o_wb_sel` out 4: always 4'hf during a transfer.
- `o_wb_wdata` out 32: rotated row data.
- `i_wb_ack`, `i_wb_stall` in 1 each: slave responses.

## Operation
- **Frame buffer:** 8×32 bits. `i_load_we` writes `buffer[i_load_row] <= i_load_data`. Loads are accepted in any state.
- **Rotation:** the data written for row r is `rotl(buffer[r], 4*offset)`. Offset 1 turns 0x12345678 into 0x23456781.
- **Data capture:** `o_wb_wdata` is captured from the buffer when REQ is entered for that row. A load to the same row in the same cycle is not seen; the old value is used.
- **Timer:**
  - Increments each cycle while `i_enable` is high, `i_period` ≠ 0, and no trigger is pending.
  - When it reaches `i_period`−1 it sets pending and clears to 0.
  - It is held at 0 while `i_enable` is low.
- **Triggers:** `i_force` also sets pending, regardless of `i_enable`. There is only one pending flag; extra triggers during a frame are merged.
- **State machine:**
  - **IDLE:** if pending, clear pending, set row=0, go to REQ.
  - **REQ:** `cyc` = `stb` = 1, `addr` = row. If `!i_wb_stall`, go to WAIT_ACK next cycle with `stb` low. If `i_wb_ack` arrives in the accept cycle, treat it as the ack and skip WAIT_ACK.
  - **WAIT_ACK:** `cyc` = 1, `stb` = 0. On `i_wb_ack`: if row = 7 go to DONE, else row+1 and go to REQ.
  - **DONE:** `cyc` = 0, pulse `o_frame_done`, update offset by ±1 mod 8 per `i_dir` (sampled here), go to IDLE.
- **Timeout:** a counter resets on entry to each REQ. If it hits `TIMEOUT` while in REQ or WAIT_ACK:
  - drop `cyc`/`stb`, set `o_err`, go to IDLE;
  - the offset is unchanged and no `o_frame_done` pulse is issued.
- **Error clear:** `i_err_clr` clears `o_err`. If a timeout sets the flag in the same cycle, set wins.
- **Disable mid-frame:** deasserting `i_enable` does not abort a frame in progress; the frame completes.

## Timing
- **Reset:** all outputs are 0 (`cyc`, `stb`, `we`, `addr`, `sel`, `wdata`, `busy`, `frame_done`, `offset`, `err`). The buffer, timer, pending flag and state (IDLE) are also cleared. Reset is asynchronous, so asserting it mid-frame drops `cyc`/`stb` immediately.
- **Latency:** pending is set in cycle T; `cyc`/`stb` for row 0 are high in T+1.
- **Throughput:** with zero stall and ack one cycle after acceptance, each row takes 2 cycles. A frame is 16 cycles of `cyc` plus 1 DONE cycle; `o_frame_done` is high in cycle T+17.
- **Stall:** while `i_wb_stall` is high, `stb`, `addr` and `wdata` hold stable.
- **Periodic rate:** frames start every `i_period` cycles, provided `i_period` ≥ 18. Shorter periods degrade to back-to-back frames.

## Test plan
- **Force, offset 0:** load rows 0..7 = 0x12345678, 0x11111111, …; `i_period`=0; pulse `i_force`. Expect 8 writes to addr 0..7 with buffer data unchanged, `o_frame_done` at T+17, then `o_offset`=1.
- **Second force, left:** with `i_dir`=0, pulse `i_force` again. Expect row 0 written as 0x23456781 and `o_offset`=2.
- **Right scroll wrap:** reset, then `i_dir`=1 and force. Expect row 0 = 0x12345678, then `o_offset`=7. Force again: row 0 = 0x81234567.
- **Stall hold:** hold `i_wb_stall`=1 for 3 cycles during row 3. Expect `stb` held with addr=3 and data unchanged; the frame ends 3 cycles late.
- **Ack timeout:** never assert ack. Expect `cyc` to drop after 255 cycles, `o_err`=1, offset unchanged, no done pulse. Then `i_err_clr` → `o_err`=0.
- **Timer and reset:** `i_enable`=1, `i_period`=40 → frame starts 40 cycles apart. Assert `reset_n`=0 mid-frame → `cyc`=0 immediately and all outputs are 0.
